// File: rtl/load_store_unit_if.sv
// Request, RAM and response signals of the load/store unit.
// The slave modport is the LSU view; the master modport is the surrounding pipeline and RAM.
interface load_store_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RIDX_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [RIDX_W-1:0] req_rd;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic [RIDX_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              st_done;
  logic              fault;
  logic [ADDR_W-1:0] fault_addr;
  logic [7:0]        fault_count;

  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, mem_read, mem_write, mem_addr, mem_wdata,
    output wb_valid, wb_rd, wb_data, st_done, fault, fault_addr, fault_count
  );

  modport master (
    output req_valid, req_store, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, mem_read, mem_write, mem_addr, mem_wdata,
    input  wb_valid, wb_rd, wb_data, st_done, fault, fault_addr, fault_count
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage in front of the data RAM: one request in flight,
// one-cycle RAM strobe, registered writeback/store/fault pulse.
module load_store_unit #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 8,
  parameter int RIDX_W    = 3
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  state_t            state, state_nx;
  logic              store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RIDX_W-1:0] rd_q;
  logic              accept;
  logic              in_range;
  logic              is_acc;

  assign bus.req_ready = rst_n & (state == IDLE);
  assign accept        = bus.req_valid & bus.req_ready;
  assign in_range      = addr_q < DEPTH;
  assign is_acc        = state == ACCESS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = ACCESS;
      end
      ACCESS: begin
        state_nx      = RESP;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_read  = in_range & ~store_q;
        bus.mem_write = in_range & store_q;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      store_q <= bus.req_store;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rd_q    <= bus.req_rd;
    end
  end

  // Pulses are set only on the edge leaving ACCESS, so they clear by themselves after RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_valid    <= 1'b0;
      bus.st_done     <= 1'b0;
      bus.fault       <= 1'b0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
      bus.fault_addr  <= '0;
      bus.fault_count <= '0;
    end else begin
      bus.wb_valid <= is_acc & in_range & ~store_q;
      bus.st_done  <= is_acc & in_range & store_q;
      bus.fault    <= is_acc & ~in_range;
      if (is_acc & in_range & ~store_q) begin
        bus.wb_data <= bus.mem_rdata;
        bus.wb_rd   <= rd_q;
      end
      if (is_acc & ~in_range) begin
        bus.fault_addr <= addr_q;
        if (bus.fault_count != 8'hFF)
          bus.fault_count <= bus.fault_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with an 8-word RAM and a
// transaction-level reference model of memory, writeback and fault state.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_W(8), .ADDR_W(8), .RIDX_W(3)) bus ();

  load_store_unit #(
    .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(8), .RIDX_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [7:0] ram [8];
  logic       preload = 1'b0;
  logic [2:0] pl_idx = '0;
  logic [7:0] pl_val = '0;

  always @(posedge clk) begin
    if (preload)            ram[pl_idx] <= pl_val;
    else if (bus.mem_write) ram[bus.mem_addr[2:0]] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = (bus.mem_addr < 8'd8) ? ram[bus.mem_addr[2:0]] : 8'h00;

  logic [7:0] ref_mem [8];
  logic [7:0] exp_data;
  logic [2:0] exp_rd;
  logic [7:0] exp_faddr;
  int         exp_fcnt;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_rd    = 3'd0;
    exp_faddr = 8'h00;
    exp_fcnt  = 0;
  endtask

  task automatic chk_ram(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, ram[i], ref_mem[i]);
  endtask

  // Called at a negedge; returns at the negedge inside the response cycle.
  task automatic do_req(input logic st, input logic [7:0] a,
                        input logic [7:0] wd, input logic [2:0] rd);
    int  w;
    bit  inr;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_rd    = rd;
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("accept", bus.req_ready, 1'b1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_store = 1'($urandom);
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    bus.req_rd    = 3'($urandom);
    inr = a < 8;
    chk("acc_ready", bus.req_ready, 1'b0);
    chk("acc_read", bus.mem_read, inr & !st);
    chk("acc_write", bus.mem_write, inr & st);
    chk("acc_addr", bus.mem_addr, a);
    chk("acc_wdata", bus.mem_wdata, wd);
    chk("acc_pulse", {bus.wb_valid, bus.st_done, bus.fault}, 3'b000);
    @(negedge clk);
    if (inr && st) ref_mem[a[2:0]] = wd;
    if (inr && !st) begin
      exp_data = ref_mem[a[2:0]];
      exp_rd   = rd;
    end
    if (!inr) begin
      exp_faddr = a;
      exp_fcnt  = (exp_fcnt >= 255) ? 255 : exp_fcnt + 1;
    end
    chk("rsp_wb_valid", bus.wb_valid, inr & !st);
    chk("rsp_st_done", bus.st_done, inr & st);
    chk("rsp_fault", bus.fault, !inr);
    chk("rsp_wb_data", bus.wb_data, exp_data);
    if (inr && !st) chk("rsp_wb_rd", bus.wb_rd, exp_rd);
    chk("rsp_faddr", bus.fault_addr, exp_faddr);
    chk("rsp_fcnt", bus.fault_count, exp_fcnt);
    chk("rsp_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rsp_mem_addr", bus.mem_addr, 8'h00);
    chk("rsp_ready", bus.req_ready, 1'b0);
  endtask

  logic [7:0] q_addr [4];
  logic [2:0] q_rd   [4];
  int         acc_cyc [$];
  logic [10:0] got_wb [$];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;
    model_reset();

    preload = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_idx = 3'(i);
      pl_val = 8'($urandom);
      ref_mem[i] = pl_val;
    end
    @(negedge clk);
    preload = 1'b0;
    chk("rst_ready", bus.req_ready, 1'b0);
    chk("rst_pulses", {bus.wb_valid, bus.st_done, bus.fault}, 3'b000);
    chk("rst_wb", {bus.wb_rd, bus.wb_data}, 11'h0);
    chk("rst_fault", {bus.fault_addr, bus.fault_count}, 16'h0);
    chk("rst_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    rst_n = 1'b1;
    #1 chk("first_ready", bus.req_ready, 1'b1);
    @(negedge clk);

    do_req(1'b1, 8'h03, 8'hA5, 3'd0);
    @(negedge clk);
    do_req(1'b0, 8'h03, 8'h00, 3'd5);
    chk("t1_wb_rd", bus.wb_rd, 3'd5);
    chk("t1_wb_data", bus.wb_data, 8'hA5);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      q_addr[i] = 8'($urandom_range(0, 7));
      q_rd[i]   = 3'(i + 1);
    end
    bus.req_valid = 1'b1;
    bus.req_store = 1'b0;
    bus.req_addr  = q_addr[0];
    bus.req_rd    = q_rd[0];
    begin
      int  idx;
      bit  adv;
      int  ready_hi;
      idx = 0;
      adv = 0;
      ready_hi = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
        if (adv) begin
          idx++;
          if (idx < 4) begin
            bus.req_addr = q_addr[idx];
            bus.req_rd   = q_rd[idx];
          end else begin
            bus.req_valid = 1'b0;
          end
          adv = 0;
        end
        if (bus.wb_valid) got_wb.push_back({bus.wb_rd, bus.wb_data});
        if (bus.req_valid && bus.req_ready) begin
          acc_cyc.push_back(cyc);
          ready_hi++;
          adv = 1;
        end
        @(negedge clk);
      end
      chk("t2_accepts", ready_hi, 4);
    end
    chk("t2_acc_n", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("t2_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    chk("t2_wb_n", got_wb.size(), 4);
    for (int i = 0; i < got_wb.size() && i < 4; i++)
      chk("t2_wb_order", got_wb[i], {q_rd[i], ref_mem[q_addr[i][2:0]]});
    exp_data = ref_mem[q_addr[3][2:0]];
    exp_rd   = q_rd[3];

    do_req(1'b0, 8'h08, 8'h00, 3'd2);
    @(negedge clk);
    do_req(1'b1, 8'hFF, 8'h5A, 3'd0);
    chk("t3_faddr", bus.fault_addr, 8'hFF);
    chk("t3_fcnt", bus.fault_count, 8'd2);
    chk_ram("t3_ram");
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 7))
                                     : 8'($urandom_range(8, 255));
      do_req(1'($urandom), a, 8'($urandom), 3'($urandom));
      @(negedge clk);
    end
    chk_ram("rand_ram");

    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom), 8'($urandom_range(8, 255)), 8'($urandom), 3'($urandom));
      @(negedge clk);
    end
    chk("t4_sat", bus.fault_count, 8'd255);
    do_req(1'b0, 8'($urandom_range(8, 255)), 8'h00, 3'd1);
    chk("t4_301_fault", bus.fault, 1'b1);
    chk("t4_301_cnt", bus.fault_count, 8'd255);
    @(negedge clk);

    do_req(1'b1, 8'h01, 8'h11, 3'd0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_store = 1'b1;
    bus.req_addr  = 8'h01;
    bus.req_wdata = 8'h3C;
    chk("t5_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("t5_write_on", bus.mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_write_off", bus.mem_write, 1'b0);
    chk("t5_addr_off", bus.mem_addr, 8'h00);
    chk("t5_ready_rst", bus.req_ready, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t5_ready_rel", bus.req_ready, 1'b1);
    chk("t5_fcnt", bus.fault_count, 8'd0);
    chk("t5_wb_data", bus.wb_data, 8'h00);
    @(negedge clk);
    chk("t5_no_done", bus.st_done, 1'b0);
    chk("t5_ram", ram[1], 8'h11);
    do_req(1'b0, 8'h01, 8'h00, 3'd6);
    chk("t5_load", bus.wb_data, 8'h11);
    @(negedge clk);

    begin
      int done_n;
      done_n = 0;
      bus.req_valid = 1'b1;
      bus.req_store = 1'b1;
      bus.req_addr  = 8'h06;
      bus.req_wdata = 8'h77;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_wdata = 8'h88;
      for (int i = 0; i < 6; i++) begin
        if (bus.st_done) done_n++;
        @(negedge clk);
      end
      ref_mem[6] = 8'h77;
      chk("t6_done_once", done_n, 1);
      chk("t6_ram", ram[6], 8'h77);
    end
    chk_ram("end_ram");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
